// File: rtl/spmv_pkg.sv
// Shared encodings for the multi-channel SpMV ops sequencer: FSM states,
// command/status word layout and a lowest-set-bit helper for channel selection.
package spmv_pkg;

    localparam logic [2:0] ST_POLL   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_NEXT   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        StPoll   = ST_POLL,
        StLaunch = ST_LAUNCH,
        StRun    = ST_RUN,
        StNext   = ST_NEXT,
        StWrite  = ST_WRITE,
        StDone   = ST_DONE
    } state_t;

    localparam int unsigned STAT_GO        = 0;
    localparam int unsigned STAT_DONE      = 1;
    localparam int unsigned STAT_ERR       = 2;
    localparam int unsigned STAT_TMASK_LSB = 8;
    localparam int unsigned MASK_LSB       = 8;

    // Channels run in ascending order, so the next one is the lowest set bit.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/spmv_ch_mux.sv
// Combinational selection of the active engine's SRAM A/B ports; all outputs
// are zero unless the sequencer is in RUN.
module spmv_ch_mux #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned CH_W   = 2
) (
    input  logic                     run,
    input  logic [CH_W-1:0]          sel,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address_a,
    input  logic [NUM_CH-1:0]        ch_wr_en_a,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address_b,
    input  logic [NUM_CH-1:0]        ch_wr_en_b,
    input  logic [NUM_CH*DATA_W-1:0] ch_write_data_b,
    output logic [ADDR_W-1:0]        address_a,
    output logic                     wr_en_a,
    output logic [ADDR_W-1:0]        address_b,
    output logic                     wr_en_b,
    output logic [DATA_W-1:0]        write_data_b
);

    always_comb begin
        address_a    = '0;
        wr_en_a      = 1'b0;
        address_b    = '0;
        wr_en_b      = 1'b0;
        write_data_b = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (run && sel == CH_W'(k)) begin
                address_a    = ch_address_a[k*ADDR_W +: ADDR_W];
                wr_en_a      = ch_wr_en_a[k];
                address_b    = ch_address_b[k*ADDR_W +: ADDR_W];
                wr_en_b      = ch_wr_en_b[k];
                write_data_b = ch_write_data_b[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/spmv_ops_sequencer.sv
// Polls a command word, runs the enabled SpMV engines one at a time with a
// per-channel watchdog, then writes a status word back and raises an IRQ.
module spmv_ops_sequencer
    import spmv_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned POLL_ADDR = 0,
    parameter int unsigned TIMEOUT   = 1024,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DATA_W-1:0]        i_read_data_A,
    output logic [ADDR_W-1:0]        o_address_A,
    output logic                     o_wr_en_A,
    output logic [DATA_W-1:0]        o_write_data_A,
    output logic [ADDR_W-1:0]        o_address_B,
    output logic                     o_wr_en_B,
    output logic [DATA_W-1:0]        o_write_data_B,
    input  logic [NUM_CH*ADDR_W-1:0] i_ch_address_A,
    input  logic [NUM_CH-1:0]        i_ch_wr_en_A,
    input  logic [NUM_CH*ADDR_W-1:0] i_ch_address_B,
    input  logic [NUM_CH-1:0]        i_ch_wr_en_B,
    input  logic [NUM_CH*DATA_W-1:0] i_ch_write_data_B,
    input  logic [NUM_CH-1:0]        i_ch_done,
    output logic [NUM_CH-1:0]        o_ch_start,
    output logic [NUM_CH-1:0]        o_ch_abort,
    output logic [2:0]               o_state,
    output logic [CH_W-1:0]          o_active_ch,
    output logic                     o_done,
    output logic                     o_irq,
    input  logic                     i_irq_clr
);

    localparam int unsigned WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    state_t              state;
    logic                poll_vld;
    logic [NUM_CH-1:0]   mask;
    logic [NUM_CH-1:0]   tmask;
    logic [CH_W-1:0]     active;
    logic [WD_W-1:0]     wd;
    logic [NUM_CH-1:0]   start;
    logic                done_pulse;
    logic                irq;

    logic                run;
    logic [NUM_CH-1:0]   onehot_act;
    logic [NUM_CH-1:0]   cmd_mask;
    logic [NUM_CH-1:0]   rem_mask;
    logic [CH_W-1:0]     first_cmd;
    logic [CH_W-1:0]     first_rem;
    logic                act_done;
    logic                timeout_hit;
    logic [DATA_W-1:0]   status;
    logic [ADDR_W-1:0]   mux_address_a;
    logic                mux_wr_en_a;
    logic                unused_rd;

    assign run         = (state == StRun);
    assign onehot_act  = NUM_CH'(1) << active;
    assign cmd_mask    = i_read_data_A[MASK_LSB +: NUM_CH];
    assign rem_mask    = mask & ~onehot_act;
    assign first_cmd   = CH_W'(lowest_set(8'(cmd_mask)));
    assign first_rem   = CH_W'(lowest_set(8'(rem_mask)));
    assign act_done    = run && |(i_ch_done & onehot_act);
    // A done arriving on the timeout cycle takes priority over the abort.
    assign timeout_hit = run && (TIMEOUT != 0) && (wd == WD_LIMIT) && !act_done;
    assign unused_rd   = ^{i_read_data_A[DATA_W-1:MASK_LSB+NUM_CH],
                           i_read_data_A[MASK_LSB-1:1]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= StPoll;
            poll_vld   <= 1'b0;
            mask       <= '0;
            tmask      <= '0;
            active     <= '0;
            wd         <= '0;
            start      <= '0;
            done_pulse <= 1'b0;
            irq        <= 1'b0;
        end else begin
            start      <= '0;
            done_pulse <= 1'b0;
            irq        <= (state == StDone) || (irq && !i_irq_clr);
            unique case (state)
                StPoll: begin
                    poll_vld <= 1'b1;
                    if (poll_vld && i_read_data_A[STAT_GO]) begin
                        poll_vld <= 1'b0;
                        mask     <= cmd_mask;
                        if (|cmd_mask) begin
                            active <= first_cmd;
                            start  <= NUM_CH'(1) << first_cmd;
                            state  <= StLaunch;
                        end else begin
                            state  <= StWrite;
                        end
                    end
                end
                StLaunch: begin
                    wd    <= '0;
                    state <= StRun;
                end
                StRun: begin
                    wd <= wd + 1'b1;
                    if (act_done) begin
                        state <= StNext;
                    end else if (timeout_hit) begin
                        tmask <= tmask | onehot_act;
                        state <= StNext;
                    end
                end
                StNext: begin
                    mask <= rem_mask;
                    if (|rem_mask) begin
                        active <= first_rem;
                        start  <= NUM_CH'(1) << first_rem;
                        state  <= StLaunch;
                    end else begin
                        state  <= StWrite;
                    end
                end
                StWrite: begin
                    done_pulse <= 1'b1;
                    state      <= StDone;
                end
                StDone: begin
                    tmask <= '0;
                    state <= StPoll;
                end
                default: state <= StPoll;
            endcase
        end
    end

    always_comb begin
        status                          = '0;
        status[STAT_TMASK_LSB +: 8]     = 8'(tmask);
        status[STAT_ERR]                = |tmask;
        status[STAT_DONE]               = 1'b1;
    end

    spmv_ch_mux #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) u_mux (
        .run             (run),
        .sel             (active),
        .ch_address_a    (i_ch_address_A),
        .ch_wr_en_a      (i_ch_wr_en_A),
        .ch_address_b    (i_ch_address_B),
        .ch_wr_en_b      (i_ch_wr_en_B),
        .ch_write_data_b (i_ch_write_data_B),
        .address_a       (mux_address_a),
        .wr_en_a         (mux_wr_en_a),
        .address_b       (o_address_B),
        .wr_en_b         (o_wr_en_B),
        .write_data_b    (o_write_data_B)
    );

    always_comb begin
        o_address_A    = ADDR_W'(POLL_ADDR);
        o_wr_en_A      = 1'b0;
        o_write_data_A = '0;
        if (run) begin
            o_address_A = mux_address_a;
            o_wr_en_A   = mux_wr_en_a;
        end else if (state == StWrite) begin
            o_wr_en_A      = 1'b1;
            o_write_data_A = status;
        end
    end

    assign o_ch_start  = start;
    assign o_ch_abort  = timeout_hit ? onehot_act : '0;
    assign o_state     = state;
    assign o_active_ch = active;
    assign o_done      = done_pulse;
    assign o_irq       = irq;

endmodule

// File: tb/tb_spmv_ops_sequencer.sv
// Directed plus randomized bench: SRAM A and engine models in the bench, expected
// start order, aborts and status word derived from the command and engine delays.
module tb_spmv_ops_sequencer;

    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 5;
    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 16;
    localparam int CH_W    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DATA_W-1:0]        rd_a;
    logic [ADDR_W-1:0]        o_address_A, o_address_B;
    logic                     o_wr_en_A, o_wr_en_B;
    logic [DATA_W-1:0]        o_write_data_A, o_write_data_B;
    logic [NUM_CH*ADDR_W-1:0] ch_addr_a, ch_addr_b;
    logic [NUM_CH-1:0]        ch_we_a, ch_we_b, ch_done, noise;
    logic [NUM_CH*DATA_W-1:0] ch_wd_b;
    logic [NUM_CH-1:0]        o_ch_start, o_ch_abort;
    logic [2:0]               o_state;
    logic [CH_W-1:0]          o_active_ch;
    logic                     o_done, o_irq, i_irq_clr;

    spmv_ops_sequencer #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_CH    (NUM_CH),
        .POLL_ADDR (0),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_read_data_A     (rd_a),
        .o_address_A       (o_address_A),
        .o_wr_en_A         (o_wr_en_A),
        .o_write_data_A    (o_write_data_A),
        .o_address_B       (o_address_B),
        .o_wr_en_B         (o_wr_en_B),
        .o_write_data_B    (o_write_data_B),
        .i_ch_address_A    (ch_addr_a),
        .i_ch_wr_en_A      (ch_we_a),
        .i_ch_address_B    (ch_addr_b),
        .i_ch_wr_en_B      (ch_we_b),
        .i_ch_write_data_B (ch_wd_b),
        .i_ch_done         (ch_done),
        .o_ch_start        (o_ch_start),
        .o_ch_abort        (o_ch_abort),
        .o_state           (o_state),
        .o_active_ch       (o_active_ch),
        .o_done            (o_done),
        .o_irq             (o_irq),
        .i_irq_clr         (i_irq_clr)
    );

    // SRAM A: synchronous read, read-before-write; host writes address 0.
    logic [DATA_W-1:0] mem_a [32] = '{default: '0};
    logic              host_we;
    logic [DATA_W-1:0] host_data;
    always @(posedge clk) begin
        rd_a <= mem_a[o_address_A];
        if (o_wr_en_A) mem_a[o_address_A] <= o_write_data_A;
        if (host_we) mem_a[0] <= host_data;
    end

    // Engines: busy from start until done or abort; done after delay[k] busy cycles.
    int   delay [NUM_CH];
    int   cnt   [NUM_CH];
    logic [NUM_CH-1:0] busy;
    bit   noise_en;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int k = 0; k < NUM_CH; k++) cnt[k] <= 0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (o_ch_start[k]) begin
                    busy[k] <= 1'b1;
                    cnt[k]  <= 0;
                end else if (busy[k] && (ch_done[k] || o_ch_abort[k])) begin
                    busy[k] <= 1'b0;
                end else if (busy[k]) begin
                    cnt[k] <= cnt[k] + 1;
                end
            end
        end
    end

    always_comb begin
        ch_done = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (busy[k]) ch_done[k] = (delay[k] != 0) && (cnt[k] == delay[k] - 1);
            else         ch_done[k] = noise_en && noise[k];
        end
    end

    always @(posedge clk) begin
        ch_addr_a <= 20'($urandom);
        ch_addr_b <= 20'($urandom);
        ch_we_a   <= 4'($urandom);
        ch_we_b   <= 4'($urandom);
        noise     <= 4'($urandom);
        for (int i = 0; i < NUM_CH * DATA_W / 32; i++) ch_wd_b[i*32 +: 32] <= $urandom;
    end

    // Event monitor, sampled on the falling edge.
    int start_log[$], abort_log[$], abort_at[$], status_addr[$];
    logic [DATA_W-1:0] status_log[$];
    int done_cnt = 0;
    int mux_err  = 0;
    int run_idx  = 0;
    always @(negedge clk) begin
        int act;
        act = -1;
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (busy[k]) act = k;
                if (o_ch_start[k]) start_log.push_back(k);
                if (o_ch_abort[k]) begin
                    abort_log.push_back(k);
                    abort_at.push_back(run_idx);
                end
            end
            if (o_done) done_cnt++;
            if (act >= 0) begin
                if (o_address_A !== ch_addr_a[act*ADDR_W +: ADDR_W] || o_wr_en_A !== ch_we_a[act] ||
                    o_address_B !== ch_addr_b[act*ADDR_W +: ADDR_W] || o_wr_en_B !== ch_we_b[act] ||
                    o_write_data_B !== ch_wd_b[act*DATA_W +: DATA_W] ||
                    o_active_ch !== CH_W'(act))
                    mux_err++;
                run_idx++;
            end else begin
                if (o_address_B !== '0 || o_wr_en_B !== 1'b0 || o_write_data_B !== '0) mux_err++;
                run_idx = 0;
                if (o_wr_en_A) begin
                    status_log.push_back(o_write_data_A);
                    status_addr.push_back(int'(o_address_A));
                end
            end
        end
    end

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic host_write(input logic [DATA_W-1:0] v);
        @(negedge clk);
        host_we   = 1'b1;
        host_data = v;
        @(negedge clk);
        host_we   = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [3:0] m, input int d0, input int d1,
                           input int d2, input int d3, input bit clr_in_done);
        int   dl [NUM_CH];
        int   exp_starts[$];
        int   exp_aborts[$];
        logic [7:0] tm;
        logic [DATA_W-1:0] exp_status;
        bit   seen;
        int   dc0;
        dl = '{d0, d1, d2, d3};
        tm = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            delay[k] = dl[k];
            if (m[k]) begin
                exp_starts.push_back(k);
                // Timed out if never done, or done would land after the watchdog limit.
                if (dl[k] == 0 || dl[k] > TIMEOUT + 1) begin
                    tm[k] = 1'b1;
                    exp_aborts.push_back(k);
                end
            end
        end
        exp_status = (DATA_W'(tm) << 8) | (DATA_W'(|tm) << 2) | DATA_W'(2);
        start_log.delete(); abort_log.delete(); abort_at.delete();
        status_log.delete(); status_addr.delete();
        mux_err = 0;
        dc0 = done_cnt;
        host_write(DATA_W'({m, 8'h01}));
        seen = 0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1;
                if (clr_in_done) i_irq_clr = 1'b1;
            end
        end
        check({name, " done_seen"}, DATA_W'(seen), DATA_W'(1));
        @(negedge clk);
        i_irq_clr = 1'b0;
        repeat (20) @(negedge clk);
        check({name, " n_starts"}, DATA_W'(start_log.size()), DATA_W'(exp_starts.size()));
        for (int i = 0; i < exp_starts.size(); i++)
            check({name, " start_ch"}, DATA_W'(start_log.size() > i ? start_log[i] : -1),
                  DATA_W'(exp_starts[i]));
        check({name, " n_aborts"}, DATA_W'(abort_log.size()), DATA_W'(exp_aborts.size()));
        for (int i = 0; i < exp_aborts.size(); i++) begin
            check({name, " abort_ch"}, DATA_W'(abort_log.size() > i ? abort_log[i] : -1),
                  DATA_W'(exp_aborts[i]));
            check({name, " abort_cycle"}, DATA_W'(abort_at.size() > i ? abort_at[i] : -1),
                  DATA_W'(TIMEOUT));
        end
        check({name, " n_status"}, DATA_W'(status_log.size()), DATA_W'(1));
        if (status_log.size() > 0) begin
            check({name, " status"}, status_log[0], exp_status);
            check({name, " status_addr"}, DATA_W'(status_addr[0]), DATA_W'(0));
        end
        check({name, " mem_status"}, mem_a[0], exp_status);
        check({name, " done_count"}, DATA_W'(done_cnt - dc0), DATA_W'(1));
        check({name, " mux"}, DATA_W'(mux_err), DATA_W'(0));
        check({name, " irq_set"}, DATA_W'(o_irq), DATA_W'(1));
        i_irq_clr = 1'b1;
        @(negedge clk);
        i_irq_clr = 1'b0;
        check({name, " irq_clr"}, DATA_W'(o_irq), DATA_W'(0));
    endtask

    initial begin
        bit up;
        rst       = 1'b1;
        host_we   = 1'b0;
        host_data = '0;
        i_irq_clr = 1'b0;
        noise_en  = 1'b1;
        for (int k = 0; k < NUM_CH; k++) delay[k] = 0;
        #1;
        check("rst state", DATA_W'(o_state), DATA_W'(0));
        check("rst addr_a", DATA_W'(o_address_A), DATA_W'(0));
        check("rst we_a", DATA_W'(o_wr_en_A), DATA_W'(0));
        check("rst wd_a", o_write_data_A, '0);
        check("rst addr_b", DATA_W'(o_address_B), DATA_W'(0));
        check("rst we_b", DATA_W'(o_wr_en_B), DATA_W'(0));
        check("rst wd_b", o_write_data_B, '0);
        check("rst start", DATA_W'(o_ch_start), DATA_W'(0));
        check("rst abort", DATA_W'(o_ch_abort), DATA_W'(0));
        check("rst done", DATA_W'(o_done), DATA_W'(0));
        check("rst irq", DATA_W'(o_irq), DATA_W'(0));
        check("rst active", DATA_W'(o_active_ch), DATA_W'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_cmd("all4",    4'hF, 10, 10, 10, 10, 0);
        run_cmd("ch1_ch3", 4'hA,  7,  5,  9,  3, 0);
        run_cmd("tmo_ch2", 4'h4,  5,  5,  0,  5, 0);
        run_cmd("empty",   4'h0,  3,  3,  3,  3, 0);
        run_cmd("tie",     4'h2,  1, TIMEOUT + 1, 1, 1, 1);
        for (int r = 0; r < 8; r++)
            run_cmd("rand", 4'($urandom_range(0, 15)), $urandom_range(0, 20),
                    $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                    1'($urandom_range(0, 1)));

        // Reset in the middle of a channel run.
        for (int k = 0; k < NUM_CH; k++) delay[k] = 0;
        host_write(DATA_W'(16'h0101));
        up = 0;
        for (int n = 0; n < 100 && !up; n++) begin
            @(negedge clk);
            up = busy[0];
        end
        check("midrst running", DATA_W'(up), DATA_W'(1));
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst state", DATA_W'(o_state), DATA_W'(0));
        check("midrst we_a", DATA_W'(o_wr_en_A), DATA_W'(0));
        check("midrst we_b", DATA_W'(o_wr_en_B), DATA_W'(0));
        check("midrst addr_b", DATA_W'(o_address_B), DATA_W'(0));
        check("midrst abort", DATA_W'(o_ch_abort), DATA_W'(0));
        host_write('0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start_log.delete();
        status_log.delete();
        repeat (20) @(negedge clk);
        check("midrst poll_addr", DATA_W'(o_address_A), DATA_W'(0));
        check("midrst no_status", DATA_W'(status_log.size()), DATA_W'(0));
        check("midrst no_start", DATA_W'(start_log.size()), DATA_W'(0));
        check("midrst irq", DATA_W'(o_irq), DATA_W'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
